// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and sizing helpers for the parametrised FIFO.
`default_nettype none

package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Pointer carries one extra wrap bit so full and empty stay distinguishable.
  function automatic int fifo_ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int FIFO_PTR_W = fifo_ptr_w(FIFO_DEPTH);

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array with one synchronous write port and
// one registered, read-enabled read port.
`default_nettype none

module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage is deliberately left out of reset; empty hides stale contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO using all DEPTH entries, with
// occupancy count, almost-full/almost-empty flags and sticky error flags.
`default_nettype none

module fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 1
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [WIDTH-1:0]              data_in_i,
  input  logic                          wn_i,
  input  logic                          rn_i,
  input  logic                          clr_err_i,
  output logic [WIDTH-1:0]              data_out_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          almost_full_o,
  output logic                          almost_empty_o,
  output logic [fifo_ptr_w(DEPTH)-1:0]  count_o,
  output logic                          overflow_o,
  output logic                          underflow_o
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_param: WIDTH must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_param: DEPTH must be a power of two and at least 2");
  end
  if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_afull
    $error("fifo_param: AFULL_TH must lie in 1..DEPTH");
  end
  if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_aempty
    $error("fifo_param: AEMPTY_TH must lie in 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty, wr_ok, rd_ok;

  always_comb begin
    full        = (count_q == PTR_W'(DEPTH));
    empty       = (count_q == '0);
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_ok       = wn_i & (~full | (rn_i & ~empty));
    rd_ok       = rn_i & ~empty;
    wptr_d      = wptr_q + PTR_W'(wr_ok);
    rptr_d      = rptr_q + PTR_W'(rd_ok);
    count_d     = wptr_d - rptr_d;
    overflow_d  = overflow_q & ~clr_err_i;
    underflow_d = underflow_q & ~clr_err_i;
    if (wn_i & ~wr_ok) begin
      overflow_d = 1'b1;
    end
    if (rn_i & empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .we_i    (wr_ok & ~reset_i),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (data_in_i),
    .re_i    (rd_ok),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (data_out_o)
  );

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= PTR_W'(AFULL_TH));
  assign almost_empty_o = (count_q <= PTR_W'(AEMPTY_TH));
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed and randomized checks of fifo_param against a
// queue-based reference model.
`default_nettype none

module tb_fifo_param;

  localparam int W     = 8;
  localparam int D     = 8;
  localparam int CW    = 4;
  localparam int AF_TH = 6;
  localparam int AE_TH = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  din = '0;
  logic          wn  = 1'b0;
  logic          rn  = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  dout;
  logic          full, empty, afull, aempty, ovf, unf;
  logic [CW-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout = '0;
  logic         m_ovf  = 1'b0;
  logic         m_unf  = 1'b0;

  fifo_param #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AFULL_TH  (AF_TH),
    .AEMPTY_TH (AE_TH)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .data_in_i      (din),
    .wn_i           (wn),
    .rn_i           (rn),
    .clr_err_i      (clr),
    .data_out_o     (dout),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (afull),
    .almost_empty_o (aempty),
    .count_o        (count),
    .overflow_o     (ovf),
    .underflow_o    (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = mq.size();
    check({ctx, ":count"},  32'(count),  32'(n));
    check({ctx, ":full"},   32'(full),   32'(n == D));
    check({ctx, ":empty"},  32'(empty),  32'(n == 0));
    check({ctx, ":afull"},  32'(afull),  32'(n >= AF_TH));
    check({ctx, ":aempty"}, 32'(aempty), 32'(n <= AE_TH));
    check({ctx, ":dout"},   32'(dout),   32'(m_dout));
    check({ctx, ":ovf"},    32'(ovf),    32'(m_ovf));
    check({ctx, ":unf"},    32'(unf),    32'(m_unf));
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d,
                      input logic c, input logic rs, input string ctx);
    int  n;
    bit  rd, wr;
    wn = w; rn = r; din = d; clr = c; rst = rs;
    n = mq.size();
    if (rs) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      rd = r && (n != 0);
      wr = w && ((n != D) || rd);
      if (c) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (w && !wr) m_ovf = 1'b1;
      if (r && n == 0) m_unf = 1'b1;
      if (rd) m_dout = mq.pop_front();
      if (wr) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    wn = 1'b0; rn = 1'b0; clr = 1'b0; rst = 1'b0;
    check_all(ctx);
  endtask

  initial begin
    int written;
    int iter;
    bit w, r;
    bit seen99;

    @(negedge clk);
    step(0, 0, 8'h00, 0, 1, "reset");

    // Fill with 0x01..0x08.
    for (int i = 1; i <= D; i++) begin
      step(1, 0, W'(i), 0, 0, $sformatf("fill%0d", i));
    end
    check("fill:full_after_8", 32'(full), 32'd1);

    // Overflow attempt while full.
    step(1, 0, 8'h99, 0, 0, "ovf_write");
    check("ovf:flag_set", 32'(ovf), 32'd1);
    seen99 = 1'b0;
    for (int i = 1; i <= D; i++) begin
      step(0, 1, 8'h00, 0, 0, $sformatf("drain%0d", i));
      check($sformatf("drain%0d:order", i), 32'(dout), 32'(i));
      if (dout == 8'h99) seen99 = 1'b1;
    end
    check("ovf:no_0x99_seen", 32'(seen99), 32'd0);
    step(0, 0, 8'h00, 1, 0, "clr_err");
    check("clr_err:ovf_low", 32'(ovf), 32'd0);

    // Underflow and simultaneous access when empty.
    step(0, 0, 8'h00, 0, 1, "reset2");
    step(0, 1, 8'h00, 0, 0, "unf_read");
    check("unf:flag_set", 32'(unf), 32'd1);
    step(1, 1, 8'hA5, 0, 0, "empty_both");
    check("empty_both:no_bypass", 32'(dout), 32'd0);

    // Full-plus-both.
    step(0, 0, 8'h00, 0, 1, "reset3");
    for (int i = 0; i < D; i++) begin
      step(1, 0, W'(8'h10 + i), 0, 0, $sformatf("fill10_%0d", i));
    end
    step(1, 1, 8'h20, 0, 0, "full_both");
    check("full_both:dout", 32'(dout), 32'h10);
    check("full_both:count", 32'(count), 32'd8);
    for (int i = 0; i < D; i++) begin
      step(0, 1, 8'h00, 0, 0, $sformatf("drain10_%0d", i));
    end
    check("full_both:last_word", 32'(dout), 32'h20);

    // Wrap-around streaming with 0 < count < D.
    step(0, 0, 8'h00, 0, 1, "reset4");
    for (int i = 0; i < 4; i++) begin
      step(1, 0, W'($urandom), 0, 0, "prime");
    end
    written = 0;
    iter = 0;
    while (written < 40 && iter < 2000) begin
      w = 1'($urandom);
      r = 1'($urandom);
      if (mq.size() == D - 1 && w && !r) w = 1'b0;
      if (mq.size() == 1 && r && !w) r = 1'b0;
      if (w) written++;
      step(w, r, W'($urandom), 0, 0, $sformatf("wrap%0d", iter));
      iter++;
    end
    check("wrap:completed", 32'(written >= 40), 32'd1);

    // Reset mid-operation.
    step(0, 0, 8'h00, 0, 1, "reset5");
    for (int i = 0; i < 5; i++) begin
      step(1, 0, W'(8'h50 + i), 0, 0, "pre_mid");
    end
    step(1, 1, 8'h77, 0, 1, "mid_reset");
    check("mid_reset:count", 32'(count), 32'd0);
    step(1, 0, 8'h3C, 0, 0, "post_write");
    step(0, 1, 8'h00, 0, 0, "post_read");
    check("post_read:dout", 32'(dout), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
